// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the number of shift-add / shift-subtract steps.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    localparam int ITER_COUNT = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional zero-operand shortcut that skips CALC: define MDU_EARLY_OUT_EN.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;

    // Latched operation context and the shared multiply/divide accumulator.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   rs_raw;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz;

    logic               op_signed;
    logic               op_div;
    logic               accept;
    logic               early_out;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = op[1];
    assign accept    = (state == IDLE) && start;
    assign a_abs     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign b_abs     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

`ifdef MDU_EARLY_OUT_EN
    assign early_out = op_div ? ((rs_val == '0) && (rt_val != '0))
                              : ((rs_val == '0) || (rt_val == '0));
`else
    assign early_out = 1'b0;
`endif

    // One step per cycle: multiply adds into the upper half and shifts right,
    // divide shifts the remainder left and subtracts the divisor if it fits.
    // NOTE: every variable is assigned on every path through always_comb, so no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = {1'b0, rem_shift} - {2'b00, opb};
        if (is_div) begin
            if (div_diff[WIDTH+1])
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fixed = neg_res ? -acc : acc;
        quo_fixed  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // NOTE: datapath registers carry no reset; they are always loaded on an
    // accepted start before anything reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div  <= op_div;
            rs_raw  <= rs_val;
            dz      <= op_div && (rt_val == '0);
            neg_res <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem <= op_signed && op_div && rs_val[WIDTH-1];
            opb     <= op_div ? b_abs : a_abs;
            if (early_out)
                acc <= '0;
            else
                acc <= op_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
        end else if (state == CALC) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            // NOTE: pulses default low each cycle and are raised only in FIX.
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= early_out ? FIX : CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER_COUNT - 1))
                        state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        // Divide by zero keeps the raw dividend in HI, unsigned-fixed.
                        if (dz) begin
                            hi          <= rs_raw;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= rem_fixed;
                            lo <= quo_fixed;
                        end
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic model.
// Honours MDU_EARLY_OUT_EN when the design is built with it.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata;
    logic        hi_we, lo_we;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural result of one operation, straight from MIPS arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint      sp;
        logic [63:0] ua, ub, up;
        int          sa, sb;
        edz = 1'b0;
        sa  = $signed(a);
        sb  = $signed(b);
        case (o)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                eh = sp[63:32];
                el = sp[31:0];
            end
            2'b01: begin
                ua = {32'h0, a};
                ub = {32'h0, b};
                up = ua * ub;
                eh = up[63:32];
                el = up[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    eh  = a;
                    el  = 32'hFFFF_FFFF;
                    edz = 1'b1;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'h0;
                    el = 32'h8000_0000;
                end else if (o == 2'b10) begin
                    el = sa / sb;
                    eh = sa % sb;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    function automatic bit expect_early(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        return o[1] ? (a == 0 && b != 0) : (a == 0 || b == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit in IDLE; returns at the negedge of the
    // done cycle (or after a cycle budget). With disturb set, a concurrent
    // MTHI/MTLO is issued with start, and a second start plus MTHI mid-flight.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb);
        logic [31:0] eh, el, hi_before;
        logic        edz;
        int          exp_lat, exp_busy, k, busy_cnt, flag_bad;
        model(o, a, b, eh, el, edz);
        exp_lat   = expect_early(o, a, b) ? 2 : 34;
        exp_busy  = exp_lat - 1;
        hi_before = hi;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (disturb) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = $urandom;
        end
        busy_cnt = 0;
        flag_bad = 0;
        k        = 0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
                if (disturb) check({name, " we_with_start"}, {32'h0, hi}, {32'h0, hi_before});
            end
            if (busy) busy_cnt++;
            if (div_by_zero && !done) flag_bad++;
            if (done) break;
            if (disturb && k == 3) begin
                start  = 1'b0;
                hi_we  = 1'b0;
                check({name, " we_while_busy"}, {32'h0, hi}, {32'h0, hi_before});
            end
            if (disturb && k == 2) begin
                start  = 1'b1;
                op     = ~o;
                rs_val = $urandom;
                rt_val = $urandom;
                hi_we  = 1'b1;
                wdata  = $urandom;
            end
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check({name, " latency"}, 64'(k), 64'(exp_lat));
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({name, " hi"}, {32'h0, hi}, {32'h0, eh});
        check({name, " lo"}, {32'h0, lo}, {32'h0, el});
        check({name, " dz_done"}, {63'h0, div_by_zero}, {63'h0, edz});
        check({name, " dz_stray"}, 64'(flag_bad), 64'd0);
    endtask

    initial begin
        int          dones;
        logic [31:0] a, b, lo_keep;
        logic [1:0]  o;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        rs_val = '0;
        rt_val = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        check("rst_ctl", {61'h0, busy, done, div_by_zero}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI / MTLO in IDLE.
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {32'h0, hi}, 64'h1234_5678);
        check("mthi_lo_untouched", {32'h0, lo}, 64'h0);
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", {32'h0, lo}, 64'hCAFE_F00D);
        check("mtlo_hi_untouched", {32'h0, hi}, 64'h1234_5678);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFF6, 32'd15, 1'b1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 1'b0);
        run_op("div_m5_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("mult_7x0", 2'b00, 32'd7, 32'd0, 1'b0);
        run_op("div_0_by3", 2'b10, 32'd0, 32'd3, 1'b0);

        // Randomized operations, mostly back-to-back (start in the done cycle).
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            run_op($sformatf("rnd%0d", i), o, a, b, ($urandom_range(0, 2) == 0));
        end

        // Reset mid-operation aborts it and clears HI/LO.
        lo_keep = lo;
        start  = 1'b1;
        op     = 2'b00;
        rs_val = 32'd45;
        rt_val = 32'd55;
        dones  = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin
                rs_val = 32'd3;
                rt_val = 32'd4;
            end
            if (done) dones++;
            if (k == 10) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_hi", {32'h0, hi}, 64'h0);
        check("abort_lo", {32'h0, lo}, 64'h0);
        check("abort_busy", {63'h0, busy}, 64'h0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_lo_cleared", {32'h0, lo}, 64'h0);
        if (lo_keep == 32'h0) check("abort_prev_lo_zero", {32'h0, lo_keep}, 64'h0);

        run_op("post_reset_mult", 2'b00, 32'd45, 32'd55, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
